// File: rtl/pc_next_predict.sv
// Next-PC unit: owns the fetch PC, predicts through a direct-mapped BTB with
// 2-bit saturating counters, and redirects on MEM-stage mispredictions.
module pc_next_predict #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            mem_valid,
  input  logic            mem_is_branch_jump,
  input  logic            mem_taken,
  input  logic            mem_pred_taken,
  input  logic [XLEN-1:0] mem_pc,
  input  logic [XLEN-1:0] mem_target,
  output logic [XLEN-1:0] pc_if,
  output logic            pred_taken_if,
  output logic            flush,
  output logic [31:0]     mispredict_cnt
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int TAGW = XLEN - IDXW - 2;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     mis_cnt_q, mis_cnt_d;
  logic [DEPTH-1:0] valid_q;
  logic [1:0]      ctr_q [DEPTH];
  logic [TAGW-1:0] tag_q [DEPTH];
  logic [XLEN-1:0] tgt_q [DEPTH];

  logic [IDXW-1:0] lk_idx, tr_idx;
  logic [TAGW-1:0] lk_tag, tr_tag;
  logic            lk_hit, tr_hit;
  logic            ev, mis;
  logic [XLEN-1:0] redirect_pc;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  // Lookup on the fetch PC; word-aligned bits [1:0] never participate
  assign lk_idx        = pc_q[IDXW+1:2];
  assign lk_tag        = pc_q[XLEN-1:IDXW+2];
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_if = lk_hit && ctr_q[lk_idx][1];

  assign tr_idx = mem_pc[IDXW+1:2];
  assign tr_tag = mem_pc[XLEN-1:IDXW+2];
  assign tr_hit = valid_q[tr_idx] && (tag_q[tr_idx] == tr_tag);

  assign ev          = mem_valid && mem_is_branch_jump;
  assign mis         = ev && (mem_taken != mem_pred_taken);
  assign flush       = mis;
  assign redirect_pc = mem_taken ? mem_target : mem_pc + XLEN'(4);

  // Redirect beats stall; stall beats prediction
  always_comb begin
    pc_d = pc_q;
    if (mis)
      pc_d = redirect_pc;
    else if (!stall)
      pc_d = pred_taken_if ? tgt_q[lk_idx] : pc_q + XLEN'(4);
  end

  assign mis_cnt_d = (mis && (mis_cnt_q != 32'hFFFF_FFFF)) ? mis_cnt_q + 32'd1 : mis_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      mis_cnt_q <= '0;
    end else begin
      pc_q      <= pc_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  // Training runs on every resolve event regardless of stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= 2'd1;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (ev) begin
      if (tr_hit) begin
        if (mem_taken) begin
          ctr_q[tr_idx] <= ctr_inc(ctr_q[tr_idx]);
          tgt_q[tr_idx] <= mem_target;
        end else begin
          ctr_q[tr_idx] <= ctr_dec(ctr_q[tr_idx]);
        end
      end else if (mem_taken) begin
        valid_q[tr_idx] <= 1'b1;
        tag_q[tr_idx]   <= tr_tag;
        tgt_q[tr_idx]   <= mem_target;
        ctr_q[tr_idx]   <= 2'd2;
      end
    end
  end

  assign pc_if          = pc_q;
  assign mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_pc_next_predict.sv
// Bench for pc_next_predict: directed scenarios plus randomized traffic,
// all checked against a table-based BTB model keyed by full branch address.
module tb_pc_next_predict;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, mem_valid, mem_is_branch_jump, mem_taken, mem_pred_taken;
  logic [31:0] mem_pc, mem_target;
  logic [31:0] pc_if;
  logic        pred_taken_if, flush;
  logic [31:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  pc_next_predict #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_valid(mem_valid), .mem_is_branch_jump(mem_is_branch_jump),
    .mem_taken(mem_taken), .mem_pred_taken(mem_pred_taken),
    .mem_pc(mem_pc), .mem_target(mem_target),
    .pc_if(pc_if), .pred_taken_if(pred_taken_if), .flush(flush),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: each slot remembers the full address of the branch it holds
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_val [DEPTH];
  int          m_ctr [DEPTH];
  logic [31:0] m_src [DEPTH];
  logic [31:0] m_tgt [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int slot(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_val[slot(a)] && ((m_src[slot(a)] / 4) == (a / 4));
  endfunction

  function automatic bit m_pred(input logic [31:0] a);
    return m_hit(a) && (m_ctr[slot(a)] >= 2);
  endfunction

  task automatic model_reset();
    m_pc  = RPC;
    m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_val[i] = 0; m_ctr[i] = 1; m_src[i] = 0; m_tgt[i] = 0;
    end
  endtask

  task automatic idle_inputs();
    stall = 0; mem_valid = 0; mem_is_branch_jump = 0; mem_taken = 0;
    mem_pred_taken = 0; mem_pc = 0; mem_target = 0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registers
  task automatic step(input bit st, input bit mv, input bit mb, input bit mt,
                      input bit mpt, input logic [31:0] mpc, input logic [31:0] mtg);
    bit ev, mis;
    int s;
    logic [31:0] nxt;
    stall = st; mem_valid = mv; mem_is_branch_jump = mb; mem_taken = mt;
    mem_pred_taken = mpt; mem_pc = mpc; mem_target = mtg;
    #1;
    ev  = mv && mb;
    mis = ev && (mt != mpt);
    check("pred_taken", {31'b0, pred_taken_if}, {31'b0, m_pred(m_pc)});
    check("flush", {31'b0, flush}, {31'b0, mis});
    if (mis)          nxt = mt ? mtg : mpc + 32'd4;
    else if (st)      nxt = m_pc;
    else if (m_pred(m_pc)) nxt = m_tgt[slot(m_pc)];
    else              nxt = m_pc + 32'd4;
    if (ev) begin
      s = slot(mpc);
      if (m_hit(mpc)) begin
        if (mt) begin
          m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          m_tgt[s] = mtg;
        end else begin
          m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end
      end else if (mt) begin
        m_val[s] = 1; m_src[s] = mpc; m_tgt[s] = mtg; m_ctr[s] = 2;
      end
    end
    if (mis && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    m_pc = nxt;
    @(posedge clk);
    #1;
    check("pc_if", pc_if, m_pc);
    check("mispredict_cnt", mispredict_cnt, m_cnt);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  // Force pc_if to a chosen address through a not-taken mispredict at addr-4
  task automatic redirect_to(input logic [31:0] addr);
    step(0, 1, 1, 0, 1, addr - 32'd4, 32'h0);
  endtask

  logic [31:0] pool [8];
  logic [31:0] held;

  initial begin
    pool[0] = 32'h200; pool[1] = 32'h240; pool[2] = 32'h204; pool[3] = 32'h280;
    pool[4] = 32'h400; pool[5] = 32'h1000; pool[6] = 32'hFFFF_FFF8; pool[7] = 32'h300;
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset state and sequential fetch
    check("reset_pc", pc_if, RPC);
    check("reset_pred", {31'b0, pred_taken_if}, 32'd0);
    check("reset_flush", {31'b0, flush}, 32'd0);
    check("reset_cnt", mispredict_cnt, 32'd0);
    repeat (3) idle_step();
    check("seq_pc", pc_if, 32'h10C);

    // Allocate on a mispredicted taken branch, then predict it
    step(0, 1, 1, 1, 0, 32'h200, 32'h400);
    check("alloc_redirect", pc_if, 32'h400);
    check("alloc_cnt", mispredict_cnt, 32'd1);
    redirect_to(32'h200);
    check("alloc_pred", {31'b0, pred_taken_if}, 32'd1);
    idle_step();
    check("alloc_next", pc_if, 32'h400);

    // Saturate to 3, decay to 1
    repeat (3) step(0, 1, 1, 1, 1, 32'h200, 32'h400);
    repeat (2) step(0, 1, 1, 0, 0, 32'h200, 32'h0);
    redirect_to(32'h200);
    check("decay_pred", {31'b0, pred_taken_if}, 32'd0);
    idle_step();
    check("decay_next", pc_if, 32'h204);

    // Stall holds, redirect overrides stall
    held = pc_if;
    repeat (2) step(1, 0, 0, 0, 0, 32'h0, 32'h0);
    check("stall_hold", pc_if, held);
    step(1, 1, 1, 0, 1, 32'h300, 32'h0);
    check("stall_redirect", pc_if, 32'h304);

    // Alias replacement at the same index
    step(0, 1, 1, 1, 1, 32'h200, 32'h400);
    step(0, 1, 1, 1, 1, 32'h240, 32'h500);
    redirect_to(32'h200);
    check("alias_old_miss", {31'b0, pred_taken_if}, 32'd0);
    idle_step();
    check("alias_old_next", pc_if, 32'h204);
    redirect_to(32'h240);
    check("alias_new_pred", {31'b0, pred_taken_if}, 32'd1);
    idle_step();
    check("alias_new_next", pc_if, 32'h500);

    // PC wrap
    step(0, 1, 1, 1, 0, 32'h600, 32'hFFFF_FFFC);
    check("wrap_pc", pc_if, 32'hFFFF_FFFC);
    idle_step();
    check("wrap_next", pc_if, 32'h0);

    // Asynchronous reset mid-cycle discards a pending training update
    stall = 0; mem_valid = 1; mem_is_branch_jump = 1; mem_taken = 1;
    mem_pred_taken = 0; mem_pc = 32'h700; mem_target = 32'h800;
    #1 rst = 1'b1;
    #1;
    check("async_pc", pc_if, RPC);
    check("async_cnt", mispredict_cnt, 32'd0);
    @(posedge clk);
    #1 idle_inputs();
    rst = 1'b0;
    model_reset();
    #1;
    check("post_rst_flush", {31'b0, flush}, 32'd0);
    redirect_to(32'h700);
    check("discarded_train", {31'b0, pred_taken_if}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      step(($urandom % 4) == 0, $urandom % 2 == 1, $urandom % 4 != 0,
           $urandom % 2 == 1, $urandom % 2 == 1,
           pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_next_predict.md
# pc_next_predict

Parametrised next-PC unit for the scpu datapath. It owns the PC register and predicts the next fetch address through a direct-mapped branch target buffer with 2-bit saturating counters. It corrects mispredictions signalled from the MEM stage and produces a flush request for the front-end stages. It replaces the single-cycle two-way PC select with a predicting, self-training selector.

## Interface
- `XLEN`, 32: address width.
- `DEPTH`, 16: BTB entries; must be a power of two, at least 2. `IDXW = log2(DEPTH)`; `TAGW = XLEN - IDXW - 2`.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk` input, 1 bit: the single clock; all state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `stall` input, 1 bit: holds the PC when high.
- `mem_valid` input, 1 bit: the MEM-stage instruction is valid.
- `mem_is_branch_jump` input, 1 bit: the MEM-stage instruction is a branch or jump.
- `mem_taken` input, 1 bit: the resolved branch outcome.
- `mem_pred_taken` input, 1 bit: the prediction made for this instruction at IF, carried down the pipeline.
- `mem_pc` input, `XLEN` bits: the PC of the MEM-stage instruction.
- `mem_target` input, `XLEN` bits: the resolved taken target.
- `pc_if` output, `XLEN` bits: the current fetch PC (register).
- `pred_taken_if` output, 1 bit: prediction for `pc_if` (combinational).
- `flush` output, 1 bit: mispredict redirect; squashes IF/ID/EX (combinational).
- `mispredict_cnt` output, 32 bits: saturating count of mispredictions (register).

## Operation
- **Lookup.** Index is `pc_if[IDXW+1:2]` and tag is `pc_if[XLEN-1:IDXW+2]`. A hit requires `valid[idx]` to be set and the stored tag to equal the tag.
  - `pred_taken_if = hit & ctr[idx][1]`.
  - Predicted next PC is `tgt[idx]` when taken, otherwise `pc_if + 4`.
- **Resolve.** A resolve event is `ev = mem_valid & mem_is_branch_jump`. Mispredict is `mis = ev & (mem_taken != mem_pred_taken)`, and `flush = mis`. The redirect PC is `mem_target` if `mem_taken`, else `mem_pc + 4`.
- **Next-PC priority**, highest first:
  1. reset;
  2. `mis` → redirect PC; this overrides `stall`;
  3. `stall` → hold;
  4. otherwise → predicted next PC.
- **Training.** Training happens on every `ev`, independent of `stall`. Index and tag come from `mem_pc`.
  - Entry hit:
    - taken: counter increments, saturating at 3, and target is written with `mem_target`;
    - not taken: counter decrements, saturating at 0.
  - Entry miss and taken: allocate. Set valid, write tag and target, set counter = 2 (weakly taken). This replaces any existing entry.
  - Entry miss and not taken: no change.
- **Mispredict counter.** `mispredict_cnt` increments on `mis` and saturates at 32'hFFFF_FFFF.
- **Arithmetic.** PC adds are modulo 2^XLEN; `pc + 4` wraps from 32'hFFFF_FFFC to 0. Bits [1:0] of PCs are ignored for indexing and tagging.

## Timing
- **Reset.** On reset, `pc_if` = `RESET_PC`, all valid bits = 0, all counters = 1, all targets and tags = 0, and `mispredict_cnt` = 0. After reset, `pred_taken_if` = 0 and `flush` = 0.
- **Reset mid-operation.** Assertion takes effect immediately, without waiting for a clock edge. A pending training update in that cycle is discarded.
- **Latency.**
  - Prediction is zero-cycle, combinational from `pc_if`.
  - The redirected PC appears on `pc_if` one cycle after `mis`.
  - A BTB update is visible to lookup in the cycle after the `ev` edge.
- **Same-index read and write.** When lookup and training hit the same index in one cycle, lookup sees the old contents; there is no bypass.
- **Stall with mispredict.** When `stall` and `mis` are both high, the redirect wins.
- `flush` is high for exactly the cycle in which `mis` is high.

## Test plan
- **Reset and sequential fetch.** Pulse `rst` with `RESET_PC` = 0x100, then run 3 cycles with no events → `pc_if` = 0x100, 0x104, 0x108, 0x10C; `pred_taken_if` = 0 throughout.
- **Allocate and predict.** Drive `ev` with `mem_pc` = 0x200, `mem_taken` = 1, `mem_pred_taken` = 0, `mem_target` = 0x400.
  - Same cycle: `flush` = 1.
  - Next cycle: `pc_if` = 0x400, `mispredict_cnt` = 1.
  - When `pc_if` later reaches 0x200: `pred_taken_if` = 1 and the following PC is 0x400.
- **Counter saturation and decay.** Train 0x200 taken three more times (counter 3), then not-taken twice (counter 1) → `pred_taken_if` at 0x200 = 0 and next PC = 0x204.
- **Stall versus redirect.** Hold `stall` = 1 for 2 cycles → `pc_if` is unchanged. Then assert `mis` with `mem_taken` = 0 and `mem_pc` = 0x300 while `stall` = 1 → next `pc_if` = 0x304.
- **Alias replacement.** With `DEPTH` = 16, train 0x200 taken, then train 0x240 (same index) taken to 0x500 → a lookup at 0x200 misses (`pred_taken_if` = 0) and a lookup at 0x240 predicts 0x500.
- **Wrap and async reset.** Set `pc_if` = 0xFFFF_FFFC with no prediction → next PC = 0. Assert `rst` mid-cycle → `pc_if` = `RESET_PC` before the next clock edge.
